// File: rtl/baud_tick_pkg.sv
// Shared widths and configuration types for the multi-channel baud tick generator.
// Default widths match the top-level parameter defaults.
package baud_tick_pkg;

    localparam int BT_CHANNELS = 2;
    localparam int BT_CNT_W    = 16;
    localparam int BT_FRAC_W   = 4;
    localparam int BT_OSR_W    = 5;

    typedef struct packed {
        logic [BT_CNT_W-1:0]  div;
        logic [BT_FRAC_W-1:0] frac;
        logic [BT_OSR_W-1:0]  osr;
    } bt_cfg_t;

    function automatic bt_cfg_t bt_make_cfg(
        input logic [BT_CNT_W-1:0]  div,
        input logic [BT_FRAC_W-1:0] frac,
        input logic [BT_OSR_W-1:0]  osr
    );
        bt_cfg_t cfg;
        cfg.div  = div;
        cfg.frac = frac;
        cfg.osr  = osr;
        return cfg;
    endfunction

endpackage

// File: rtl/baud_tick_chan.sv
// One baud channel: shadow/active config, fractional divider and oversample bit counter.
// Optional fractional accumulator is built only when BAUD_TICK_FRAC_EN is defined.
module baud_tick_chan
    import baud_tick_pkg::*;
#(
    parameter int CNT_W  = BT_CNT_W,
    parameter int FRAC_W = BT_FRAC_W,
    parameter int OSR_W  = BT_OSR_W
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              en,
    input  logic              cfg_load,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [FRAC_W-1:0] cfg_frac,
    input  logic [OSR_W-1:0]  cfg_osr,
    output logic              os_tick,
    output logic              bit_tick
);

    logic [CNT_W-1:0] shd_div_r;
    logic [CNT_W-1:0] act_div_r;
    logic [CNT_W-1:0] shd_div_nxt_s;
    logic [OSR_W-1:0] shd_osr_r;
    logic [OSR_W-1:0] act_osr_r;
    logic [OSR_W-1:0] shd_osr_nxt_s;
    logic [OSR_W-1:0] bit_cnt_r;
    logic [CNT_W:0]   cnt_r;
    logic [CNT_W:0]   reload_val_s;
    logic             carry_s;
    logic             reload_s;
    logic             os_tick_r;
    logic             bit_tick_r;
    logic             unused_act_div_s;

    // Shadow value as it will be after this edge, so a same-cycle load takes effect at a reload.
    always_comb begin
        shd_div_nxt_s = shd_div_r;
        shd_osr_nxt_s = shd_osr_r;
        if (cfg_load) begin
            shd_div_nxt_s = cfg_div;
            shd_osr_nxt_s = cfg_osr;
        end else begin
            shd_div_nxt_s = shd_div_r;
            shd_osr_nxt_s = shd_osr_r;
        end
    end

`ifdef BAUD_TICK_FRAC_EN
    logic [FRAC_W-1:0] shd_frac_r;
    logic [FRAC_W-1:0] act_frac_r;
    logic [FRAC_W-1:0] shd_frac_nxt_s;
    logic [FRAC_W-1:0] acc_r;
    logic [FRAC_W-1:0] sum_s;

    // Next shadow fraction and the accumulator step with its carry.
    always_comb begin
        shd_frac_nxt_s = shd_frac_r;
        if (cfg_load) begin
            shd_frac_nxt_s = cfg_frac;
        end else begin
            shd_frac_nxt_s = shd_frac_r;
        end
        {carry_s, sum_s} = {1'b0, acc_r} + {1'b0, act_frac_r};
    end

    // Fraction shadow/active registers and phase accumulator.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            shd_frac_r <= {FRAC_W{1'b0}};
            act_frac_r <= {FRAC_W{1'b0}};
            acc_r      <= {FRAC_W{1'b0}};
        end else begin
            shd_frac_r <= shd_frac_nxt_s;
            if (!en) begin
                act_frac_r <= shd_frac_nxt_s;
                acc_r      <= {FRAC_W{1'b0}};
            end else if (reload_s) begin
                act_frac_r <= shd_frac_nxt_s;
                acc_r      <= sum_s;
            end else begin
                act_frac_r <= act_frac_r;
                acc_r      <= acc_r;
            end
        end
    end
`else
    logic unused_frac_s;

    assign carry_s       = 1'b0;
    assign unused_frac_s = ^cfg_frac;
`endif

    assign reload_s     = en && (cnt_r == {(CNT_W+1){1'b0}});
    // The reload value is the divider that becomes active on this very edge.
    assign reload_val_s = {1'b0, shd_div_nxt_s} + {{CNT_W{1'b0}}, carry_s};
    assign unused_act_div_s = ^act_div_r;

    // Divider counter, bit counter, config transfer and registered tick outputs.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            shd_div_r  <= {CNT_W{1'b0}};
            act_div_r  <= {CNT_W{1'b0}};
            shd_osr_r  <= {OSR_W{1'b0}};
            act_osr_r  <= {OSR_W{1'b0}};
            bit_cnt_r  <= {OSR_W{1'b0}};
            cnt_r      <= {(CNT_W+1){1'b0}};
            os_tick_r  <= 1'b0;
            bit_tick_r <= 1'b0;
        end else begin
            shd_div_r <= shd_div_nxt_s;
            shd_osr_r <= shd_osr_nxt_s;
            if (!en) begin
                act_div_r  <= shd_div_nxt_s;
                act_osr_r  <= shd_osr_nxt_s;
                cnt_r      <= {1'b0, shd_div_nxt_s};
                bit_cnt_r  <= {OSR_W{1'b0}};
                os_tick_r  <= 1'b0;
                bit_tick_r <= 1'b0;
            end else if (reload_s) begin
                act_div_r <= shd_div_nxt_s;
                act_osr_r <= shd_osr_nxt_s;
                cnt_r     <= reload_val_s;
                os_tick_r <= 1'b1;
                // Equality (not >=) lets a shrunken osr wrap through zero with no stray bit tick.
                if (bit_cnt_r == act_osr_r) begin
                    bit_cnt_r  <= {OSR_W{1'b0}};
                    bit_tick_r <= 1'b1;
                end else begin
                    bit_cnt_r  <= bit_cnt_r + OSR_W'(1);
                    bit_tick_r <= 1'b0;
                end
            end else begin
                act_div_r  <= act_div_r;
                act_osr_r  <= act_osr_r;
                cnt_r      <= cnt_r - (CNT_W+1)'(1);
                bit_cnt_r  <= bit_cnt_r;
                os_tick_r  <= 1'b0;
                bit_tick_r <= 1'b0;
            end
        end
    end

    assign os_tick  = os_tick_r;
    assign bit_tick = bit_tick_r;

endmodule

// File: rtl/baud_tick_gen_mc.sv
// Multi-channel baud tick generator: one baud_tick_chan per channel, buses sliced per channel.
// Fractional dividers are present only when BAUD_TICK_FRAC_EN is defined.
module baud_tick_gen_mc
    import baud_tick_pkg::*;
#(
    parameter int CHANNELS = BT_CHANNELS,
    parameter int CNT_W    = BT_CNT_W,
    parameter int FRAC_W   = BT_FRAC_W,
    parameter int OSR_W    = BT_OSR_W
) (
    input  logic                       clk,
    input  logic                       aresetn,
    input  logic [CHANNELS-1:0]        ch_en,
    input  logic [CHANNELS-1:0]        cfg_load,
    input  logic [CHANNELS*CNT_W-1:0]  baud_div,
    input  logic [CHANNELS*FRAC_W-1:0] baud_frac,
    input  logic [CHANNELS*OSR_W-1:0]  osr,
    output logic [CHANNELS-1:0]        os_tick,
    output logic [CHANNELS-1:0]        bit_tick
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        baud_tick_chan #(
            .CNT_W  (CNT_W),
            .FRAC_W (FRAC_W),
            .OSR_W  (OSR_W)
        ) u_chan (
            .clk      (clk),
            .aresetn  (aresetn),
            .en       (ch_en[i]),
            .cfg_load (cfg_load[i]),
            .cfg_div  (baud_div[i*CNT_W +: CNT_W]),
            .cfg_frac (baud_frac[i*FRAC_W +: FRAC_W]),
            .cfg_osr  (osr[i*OSR_W +: OSR_W]),
            .os_tick  (os_tick[i]),
            .bit_tick (bit_tick[i])
        );
    end

endmodule

// File: tb/tb_baud_tick_gen_mc.sv
// Scoreboard bench for baud_tick_gen_mc: expected tick cycles are queued when a channel is
// started and checked by a negedge monitor; BAUD_TICK_FRAC_EN selects the fractional model.
module tb_baud_tick_gen_mc;
    import baud_tick_pkg::*;

    localparam int CH = BT_CHANNELS;
    localparam int CW = BT_CNT_W;
    localparam int FW = BT_FRAC_W;
    localparam int OW = BT_OSR_W;

    logic              clk = 1'b0;
    logic              aresetn;
    logic [CH-1:0]     ch_en;
    logic [CH-1:0]     cfg_load;
    logic [CH*CW-1:0]  baud_div;
    logic [CH*FW-1:0]  baud_frac;
    logic [CH*OW-1:0]  osr;
    logic [CH-1:0]     os_tick;
    logic [CH-1:0]     bit_tick;

    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;
    int exp_q0[$];
    int exp_q1[$];

    baud_tick_gen_mc dut (
        .clk       (clk),
        .aresetn   (aresetn),
        .ch_en     (ch_en),
        .cfg_load  (cfg_load),
        .baud_div  (baud_div),
        .baud_frac (baud_frac),
        .osr       (osr),
        .os_tick   (os_tick),
        .bit_tick  (bit_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: every os_tick must match the head of its channel queue (cycle*2+bit).
    always @(negedge clk) begin : monitor
        int obs;
        int exp_v;
        bit empty;
        for (int c = 0; c < 2; c++) begin
            if (os_tick[c] === 1'b1) begin
                obs   = cyc * 2 + int'(bit_tick[c]);
                empty = (c == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
                n_cmp++;
                if (empty) begin
                    n_err++;
                    $display("FAIL tick_unexpected ch%0d: got tick at cycle %0d bit=%0d, required none", c, cyc, bit_tick[c]);
                end else begin
                    if (c == 0) exp_v = exp_q0.pop_front();
                    else        exp_v = exp_q1.pop_front();
                    if (obs !== exp_v) begin
                        n_err++;
                        $display("FAIL tick_sched ch%0d: got cycle %0d bit=%0d, required cycle %0d bit=%0d",
                                 c, obs / 2, obs % 2, exp_v / 2, exp_v % 2);
                    end
                end
            end else if (bit_tick[c] !== 1'b0) begin
                n_cmp++;
                n_err++;
                $display("FAIL bit_without_os ch%0d: bit_tick=%b os_tick=%b at cycle %0d, required bit_tick=0", c, bit_tick[c], os_tick[c], cyc);
            end
        end
    end

    task automatic push_exp(input int ch, input int t, input int b);
        if (ch == 0) exp_q0.push_back(t * 2 + b);
        else         exp_q1.push_back(t * 2 + b);
    endtask

    // Reference model: period k = div+1 plus the carry produced by reload k-1 of k*frac/2^FW.
    task automatic push_sched(input int ch, input int t0, input int div, input int frac,
                              input int osr_v, input int n, output int t_last);
        int t;
        int carry;
        int fe;
`ifdef BAUD_TICK_FRAC_EN
        fe = frac;
`else
        fe = 0 * frac;
`endif
        t = t0;
        for (int k = 1; k <= n; k++) begin
            carry = (k >= 2) ? ((k - 1) * fe) / (1 << FW) - ((k - 2) * fe) / (1 << FW) : 0;
            t = t + div + 1 + carry;
            push_exp(ch, t, ((k % (osr_v + 1)) == 0) ? 1 : 0);
        end
        t_last = t;
    endtask

    task automatic load_cfg(input int ch, input int div, input int frac, input int osr_v);
        baud_div[ch*CW +: CW]  = CW'(div);
        baud_frac[ch*FW +: FW] = FW'(frac);
        osr[ch*OW +: OW]       = OW'(osr_v);
        cfg_load[ch] = 1'b1;
        @(negedge clk);
        cfg_load[ch] = 1'b0;
    endtask

    task automatic run_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic test_drain(input string name);
        repeat (12) @(negedge clk);
        n_cmp++;
        if ((exp_q0.size() + exp_q1.size()) !== 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d/%0d expected ticks never seen, required 0/0", name, exp_q0.size(), exp_q1.size());
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (os_tick !== 2'b00) begin
            n_err++;
            $display("FAIL reset_os_tick: got %b, required 00", os_tick);
        end
        n_cmp++;
        if (bit_tick !== 2'b00) begin
            n_err++;
            $display("FAIL reset_bit_tick: got %b, required 00", bit_tick);
        end
        aresetn = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (os_tick !== 2'b00) begin
            n_err++;
            $display("FAIL idle_os_tick: got %b, required 00", os_tick);
        end
    endtask

    task automatic test_basic;
        int t0, tl;
        load_cfg(0, 3, 0, 15);
        @(negedge clk);
        t0 = cyc;
        ch_en[0] = 1'b1;
        push_sched(0, t0, 3, 0, 15, 20, tl);
        run_until(tl);
        ch_en[0] = 1'b0;
        test_drain("basic");
    endtask

    task automatic test_frac;
        int t0, tl;
        load_cfg(0, 9, 4, 3);
        @(negedge clk);
        t0 = cyc;
        ch_en[0] = 1'b1;
        push_sched(0, t0, 9, 4, 3, 17, tl);
        run_until(tl);
        ch_en[0] = 1'b0;
        test_drain("frac");
    endtask

    task automatic test_reload_update;
        int t0;
        load_cfg(0, 3, 0, 15);
        @(negedge clk);
        t0 = cyc;
        ch_en[0] = 1'b1;
        push_exp(0, t0 + 4, 0);
        push_exp(0, t0 + 8, 0);
        push_exp(0, t0 + 16, 0);
        push_exp(0, t0 + 24, 0);
        push_exp(0, t0 + 30, 0);
        push_exp(0, t0 + 36, 0);
        run_until(t0 + 6);
        load_cfg(0, 7, 0, 15);
        run_until(t0 + 23);
        // Strobe lands exactly on the reload edge at t0+24.
        load_cfg(0, 5, 0, 15);
        run_until(t0 + 36);
        ch_en[0] = 1'b0;
        test_drain("reload_update");
    endtask

    task automatic test_independent;
        int t0, tl;
        load_cfg(0, 1, 0, 0);
        load_cfg(1, 5, 0, 1);
        @(negedge clk);
        t0 = cyc;
        ch_en = 2'b11;
        push_sched(0, t0, 1, 0, 0, 15, tl);
        push_exp(1, t0 + 6, 0);
        push_exp(1, t0 + 12, 1);
        push_exp(1, t0 + 22, 0);
        push_exp(1, t0 + 27, 1);
        run_until(t0 + 15);
        ch_en[1] = 1'b0;
        load_cfg(1, 4, 0, 1);
        @(negedge clk);
        ch_en[1] = 1'b1;
        run_until(t0 + 30);
        ch_en = 2'b00;
        test_drain("independent");
    endtask

    task automatic test_reset_mid;
        int t0, t1, tl;
        load_cfg(0, 3, 0, 15);
        @(negedge clk);
        t0 = cyc;
        ch_en[0] = 1'b1;
        push_exp(0, t0 + 4, 0);
        push_exp(0, t0 + 8, 0);
        run_until(t0 + 11);
        aresetn = 1'b0;
        ch_en[0] = 1'b0;
        #1;
        n_cmp++;
        if ({os_tick, bit_tick} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got os=%b bit=%b, required 00/00", os_tick, bit_tick);
        end
        @(negedge clk);
        n_cmp++;
        if (os_tick !== 2'b00) begin
            n_err++;
            $display("FAIL reset_mid_no_tick: got %b at cycle %0d, required 00", os_tick, cyc);
        end
        aresetn = 1'b1;
        load_cfg(0, 3, 0, 15);
        @(negedge clk);
        t1 = cyc;
        ch_en[0] = 1'b1;
        push_sched(0, t1, 3, 0, 15, 3, tl);
        run_until(tl);
        ch_en[0] = 1'b0;
        test_drain("reset_mid");
    endtask

    initial begin
        aresetn   = 1'b0;
        ch_en     = '0;
        cfg_load  = '0;
        baud_div  = '0;
        baud_frac = '0;
        osr       = '0;
        test_reset();
        test_basic();
        test_frac();
        test_reload_update();
        test_independent();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
